// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer_pkg
// Purpose  : Shared definitions for the multi-cycle multiply/divide unit:
//            OpE encodings, sequencer state encoding and default width.
// Config   : MULDIV_SEQUENCER_DIV_EN (consumed by the RTL files, not here)
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_sequencer_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,   // full product, architectural value in ResultLo
        OP_UMULL = 2'b01,   // unsigned long multiply
        OP_SMULL = 2'b10,   // signed long multiply
        OP_UDIV  = 2'b11    // unsigned divide SrcAE / SrcBE
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter_core
// Purpose  : Iterative datapath: radix-2 shift-add multiplier and (optional)
//            restoring divider sharing one 2*WIDTH accumulator.
//            Accumulator layout: multiply {partial hi, multiplier lo},
//            divide {remainder, dividend/quotient}.
// Config   : MULDIV_SEQUENCER_DIV_EN compiles in the divider and o_div_zero.
// Ports    : i_load   - latch operands (magnitudes for SMULL)
//            i_step   - perform one iteration
//            o_result - {hi, lo} the sequencer registers when it finishes;
//                       reflects the state after the current step
//            o_div_zero - latched divide with zero divisor
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter_core
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [1:0]         i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic               i_step,
`ifdef MULDIV_SEQUENCER_DIV_EN
    output logic               o_div_zero,
`endif
    output logic [2*WIDTH-1:0] o_result
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic               r_neg;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_mul_fin;

    // Only SMULL works on magnitudes; every other op uses raw operands.
    assign w_a_neg = (i_op == OP_SMULL) && i_a[WIDTH-1];
    assign w_b_neg = (i_op == OP_SMULL) && i_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign w_b_mag = w_b_neg ? (~i_b + 1'b1) : i_b;

    // Add multiplicand into the upper half when the multiplier LSB is set,
    // then shift the whole accumulator right keeping the carry.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};
    assign w_mul_fin  = r_neg ? (~w_mul_next + 1'b1) : w_mul_next;

`ifdef MULDIV_SEQUENCER_DIV_EN
    logic               r_div;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_div_next;

    // Shift the next dividend bit into the remainder and trial-subtract.
    // When the subtract succeeds the result is below the divisor, so the
    // low WIDTH bits of the modular difference are exact.
    assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_b});
    assign w_diff     = w_shift[WIDTH-1:0] - r_b;
    assign w_div_next = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                             : {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    assign o_div_zero = r_div && (r_b == '0);

    always_comb begin
        o_result = w_mul_fin;
        if (o_div_zero) begin
            // Untouched dividend is the remainder; quotient saturates.
            o_result = {r_acc[WIDTH-1:0], {WIDTH{1'b1}}};
        end else if (r_div) begin
            o_result = w_div_next;
        end
    end
`else
    assign o_result = w_mul_fin;
`endif

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_b   <= '0;
            r_neg <= 1'b0;
`ifdef MULDIV_SEQUENCER_DIV_EN
            r_div <= 1'b0;
`endif
        end else if (i_load) begin
            r_acc <= {{WIDTH{1'b0}}, w_a_mag};
            r_b   <= w_b_mag;
            r_neg <= w_a_neg ^ w_b_neg;
`ifdef MULDIV_SEQUENCER_DIV_EN
            r_div <= (i_op == OP_UDIV);
`endif
        end else if (i_step) begin
`ifdef MULDIV_SEQUENCER_DIV_EN
            r_acc <= r_div ? w_div_next : w_mul_next;
`else
            r_acc <= w_mul_next;
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : E-stage multi-cycle multiply/divide sequencer. Accepts an op
//            from IDLE or DONE, stalls the pipeline while iterating, and
//            pulses Done with registered ResultHi/ResultLo.
// Config   : MULDIV_SEQUENCER_DIV_EN - compile in DIV state and divider;
//            otherwise UDIV completes immediately with Illegal=1, results 0.
// Ports    : clk, reset (async, active-low)
//            StartE/OpE/SrcAE/SrcBE/AbortE - request from the E stage
//            StallReq (combinational) - hold F/D/E
//            ResultHi/ResultLo/Done/Illegal - registered completion outputs
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic [1:0]       OpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             AbortE,
    output logic             StallReq,
    output logic [WIDTH-1:0] ResultHi,
    output logic [WIDTH-1:0] ResultLo,
    output logic             Done,
    output logic             Illegal
);

    localparam int              C_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

    state_t             r_state;
    logic [C_CW-1:0]    r_cnt;
    logic               w_accept;
    logic               w_step;
    logic [2*WIDTH-1:0] w_result;
`ifdef MULDIV_SEQUENCER_DIV_EN
    logic               w_div_zero;
`endif

    assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && StartE && !AbortE;
    assign w_step   = ((r_state == ST_MUL) || (r_state == ST_DIV)) && !AbortE;
    assign StallReq = w_accept || w_step;

    muldiv_iter_core #(
        .WIDTH      (WIDTH)
    ) u_core (
        .clk        (clk),
        .i_rst_n    (reset),
        .i_load     (w_accept),
        .i_op       (OpE),
        .i_a        (SrcAE),
        .i_b        (SrcBE),
        .i_step     (w_step),
`ifdef MULDIV_SEQUENCER_DIV_EN
        .o_div_zero (w_div_zero),
`endif
        .o_result   (w_result)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            ResultHi <= '0;
            ResultLo <= '0;
            Done     <= 1'b0;
            Illegal  <= 1'b0;
        end else begin
            Done    <= 1'b0;
            Illegal <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        if (OpE == OP_UDIV) begin
`ifdef MULDIV_SEQUENCER_DIV_EN
                            r_state <= ST_DIV;
`else
                            r_state  <= ST_DONE;
                            Done     <= 1'b1;
                            Illegal  <= 1'b1;
                            ResultHi <= '0;
                            ResultLo <= '0;
`endif
                        end else begin
                            r_state <= ST_MUL;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (AbortE) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == C_LAST) begin
                        {ResultHi, ResultLo} <= w_result;
                        Done                 <= 1'b1;
                        r_state              <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + C_CW'(1);
                    end
                end
`ifdef MULDIV_SEQUENCER_DIV_EN
                ST_DIV: begin
                    if (AbortE) begin
                        r_state <= ST_IDLE;
                    end else if (w_div_zero || (r_cnt == C_LAST)) begin
                        {ResultHi, ResultLo} <= w_result;
                        Done                 <= 1'b1;
                        r_state              <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + C_CW'(1);
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Self-checking bench for muldiv_sequencer (WIDTH=32). Stimulus
//            pushes expected {hi, lo, illegal, done-cycle} into a queue; a
//            monitor pops and compares on every Done pulse.
// Config   : follows MULDIV_SEQUENCER_DIV_EN like the design
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         StartE;
    logic [1:0]   OpE;
    logic [W-1:0] SrcAE;
    logic [W-1:0] SrcBE;
    logic         AbortE;
    logic         StallReq;
    logic [W-1:0] ResultHi;
    logic [W-1:0] ResultLo;
    logic         Done;
    logic         Illegal;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .StartE   (StartE),
        .OpE      (OpE),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .AbortE   (AbortE),
        .StallReq (StallReq),
        .ResultHi (ResultHi),
        .ResultLo (ResultLo),
        .Done     (Done),
        .Illegal  (Illegal)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         ill;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (Done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 64'(Done), 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result_hi",  64'(ResultHi), 64'(e.hi));
                    chk("result_lo",  64'(ResultLo), 64'(e.lo));
                    chk("illegal",    64'(Illegal),  64'(e.ill));
                    chk("done_cycle", 64'(cyc),      64'(e.cyc));
                end
            end else if (Illegal) begin
                chk("illegal_without_done", 64'(Illegal), 64'd0);
            end
        end
    end

    // Drive a request; it is accepted on the next rising edge.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic eill,
                         input int lat, input bit push, output int acc);
        StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b;
        @(posedge clk); #1;
        acc = cyc;
        StartE = 1'b0;
        if (push) q.push_back('{hi: ehi, lo: elo, ill: eill, cyc: acc + lat});
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(posedge clk); n++;
        end while (q.size() != 0 && n < 300);
        #1;
        chk("drain_pending", 64'(q.size()), 64'd0);
    endtask

    task automatic run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic eill,
                       input int lat);
        int acc;
        issue(op, a, b, ehi, elo, eill, lat, 1'b1, acc);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int acc;
        int acc1;
        int stalls;
        reset = 1'b0; StartE = 1'b0; AbortE = 1'b0; OpE = 2'b00; SrcAE = '0; SrcBE = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall",   64'(StallReq), 64'd0);
        chk("rst_done",    64'(Done),     64'd0);
        chk("rst_illegal", 64'(Illegal),  64'd0);
        chk("rst_hi",      64'(ResultHi), 64'd0);
        chk("rst_lo",      64'(ResultLo), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // MUL 7*6 with stall profile
        StartE = 1'b1; OpE = 2'b00; SrcAE = 32'd7; SrcBE = 32'd6;
        @(negedge clk);
        chk("stall_accept", 64'(StallReq), 64'd1);
        @(posedge clk); #1;
        acc = cyc; StartE = 1'b0;
        q.push_back('{hi: 32'd0, lo: 32'd42, ill: 1'b0, cyc: acc + 32});
        stalls = 0;
        repeat (32) begin
            @(negedge clk);
            if (StallReq) stalls++;
        end
        chk("mul_stall_cycles", 64'(stalls), 64'd32);
        @(negedge clk);
        chk("done_stall_low", 64'(StallReq), 64'd0);
        drain();

        run(2'b10, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 32);
        run(2'b01, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 32);
        run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32);
        run(2'b10, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0, 32);
        run(2'b10, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0, 32);
        run(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001, 1'b0, 32);

`ifdef MULDIV_SEQUENCER_DIV_EN
        run(2'b11, 32'd100,       32'd7,          32'd2,         32'd14,        1'b0, 32);
        run(2'b11, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF, 1'b0, 1);
        run(2'b11, 32'hFFFF_FFFF, 32'd1,          32'd0,         32'hFFFF_FFFF, 1'b0, 32);
        run(2'b11, 32'd7,         32'd100,        32'd7,         32'd0,         1'b0, 32);
`else
        issue(2'b11, 32'd100, 32'd7, 32'd0, 32'd0, 1'b1, 0, 1'b1, acc);
        @(negedge clk);
        chk("illegal_done_stall_low", 64'(StallReq), 64'd0);
        drain();
`endif

        // Back-to-back: second request held during DONE
        issue(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 32, 1'b1, acc1);
        repeat (32) @(posedge clk);
        #1;
        issue(2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 32, 1'b1, acc);
        drain();

        // Abort in cycle 10 of MUL: no Done, results retained (0, 30)
        issue(2'b00, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 0, 1'b0, acc);
        repeat (9) @(posedge clk);
        #1;
        AbortE = 1'b1;
        @(negedge clk);
        chk("abort_stall_low", 64'(StallReq), 64'd0);
        @(posedge clk); #1;
        AbortE = 1'b0;
        @(negedge clk);
        chk("abort_idle_stall", 64'(StallReq), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_hi_kept", 64'(ResultHi), 64'd0);
        chk("abort_lo_kept", 64'(ResultLo), 64'd30);

        // StartE together with AbortE is ignored
        StartE = 1'b1; AbortE = 1'b1; OpE = 2'b00; SrcAE = 32'd2; SrcBE = 32'd2;
        @(negedge clk);
        chk("start_abort_stall", 64'(StallReq), 64'd0);
        @(posedge clk); #1;
        AbortE = 1'b0; StartE = 1'b0;
        @(negedge clk);
        chk("start_abort_no_op", 64'(StallReq), 64'd0);
        repeat (40) @(posedge clk);
        #1;

        // Reset in cycle 5 of an op
`ifdef MULDIV_SEQUENCER_DIV_EN
        issue(2'b11, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 0, 1'b0, acc);
`else
        issue(2'b00, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 0, 1'b0, acc);
`endif
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_stall",   64'(StallReq), 64'd0);
        chk("midrst_done",    64'(Done),     64'd0);
        chk("midrst_illegal", 64'(Illegal),  64'd0);
        chk("midrst_hi",      64'(ResultHi), 64'd0);
        chk("midrst_lo",      64'(ResultLo), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        chk("postrst_stall", 64'(StallReq), 64'd0);
        chk("postrst_lo",    64'(ResultLo), 64'd0);
        chk("queue_empty",   64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port StartE  input  1  E-stage instruction requests a multi-cycle op.
REQ-005 SHALL have port OpE  input  2  00 MUL (low word), 01 UMULL, 10 SMULL, 11 UDIV.
REQ-006 SHALL have ports SrcAE and SrcBE  input  WIDTH  operands; UDIV computes SrcAE/SrcBE.
REQ-007 SHALL have port AbortE  input  1  E-stage flush (wrong prediction); cancels the op.
REQ-008 SHALL have port StallReq  output  1  to hazard logic; stall F/D/E while the op is computing.
REQ-009 SHALL have ports ResultHi and ResultLo  output  WIDTH  product hi/lo, or remainder/quotient.
REQ-010 SHALL have port Done  output  1  one-cycle pulse; results valid.
REQ-011 SHALL have port Illegal  output  1  one-cycle pulse; UDIV requested while divider compiled out.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-013 IDLE: StartE=1 and AbortE=0 SHALL latch operands and OpE and go to MUL (OpE 00/01/10) or DIV (11).
REQ-014 StallReq SHALL be combinational: (IDLE or DONE) and StartE and not AbortE, or state in {MUL, DIV} and not AbortE.
REQ-015 MUL SHALL be radix-2 shift-add: exactly WIDTH cycles, then DONE.
REQ-016 SMULL SHALL multiply operand magnitudes; negate the 2*WIDTH product if the operand signs differ.
REQ-017 DIV SHALL be restoring, one quotient bit per cycle: WIDTH cycles, then DONE.
REQ-018 Divisor 0 SHALL skip iteration: DIV lasts 1 cycle; quotient all ones; remainder = SrcAE.
REQ-019 DONE SHALL last one cycle with Done=1 and StallReq deasserted; StartE there SHALL start the next op back-to-back.
REQ-020 DONE without StartE SHALL return to IDLE.
REQ-021 ResultHi/ResultLo SHALL change only on entry to DONE and hold until the next DONE.
REQ-022 AbortE in MUL or DIV SHALL return to IDLE next cycle: no Done, results unchanged, StallReq low that cycle.
REQ-023 StartE with AbortE in any state SHALL be ignored.
REQ-024 MUL (00) SHALL report the full product; ResultLo holds the architectural value.
REQ-025 Total latency SHALL be WIDTH+1 cycles from start acceptance to Done (2 for divide-by-zero).

Reset
REQ-026 reset low SHALL force IDLE; StallReq, Done and Illegal 0; ResultHi, ResultLo and internal registers 0.
REQ-027 reset asserted mid-operation SHALL discard the op; no Done after release.

Configuration
REQ-028 Macro MULDIV_SEQUENCER_DIV_EN defined SHALL compile in the DIV state and restoring divider.
REQ-029 Without MULDIV_SEQUENCER_DIV_EN, accepted OpE=11 SHALL go directly to DONE: Illegal=1, Done=1, results 0, StallReq only in the accept cycle.

Structure
REQ-030 Shared package SHALL hold the OpE encodings, the state enum and WIDTH default.
REQ-031 Datapath SHALL be sub-module muldiv_iter_core (shift/add/subtract registers); the FSM and stall logic stay in muldiv_sequencer.

Verification
REQ-032 MUL 7*6 -> StallReq high 32 cycles, Done on cycle 33, ResultLo=42, ResultHi=0.
REQ-033 SMULL -3*5 -> ResultHi=0xFFFFFFFF, ResultLo=0xFFFFFFF1; UMULL 0xFFFFFFFF*2 -> Hi=1, Lo=0xFFFFFFFE.
REQ-034 UDIV 100/7 -> Lo=14, Hi=2 at cycle 33; UDIV 5/0 -> Done on cycle 2, Lo=0xFFFFFFFF, Hi=5.
REQ-035 AbortE at cycle 10 of MUL -> IDLE next cycle; no Done; prior results retained.
REQ-036 Back-to-back: StartE held in DONE -> second op accepted without an IDLE cycle; two Done pulses 33 cycles apart.
REQ-037 reset low at cycle 5 of DIV -> all outputs 0 immediately; no Done after release.
